// File: rtl/switch_nibble_conditioner.sv
// ----------------------------------------------------------------------------
// switch_nibble_conditioner
//
// Purpose:
//   Conditions a bank of raw mechanical DIP switches into a clean,
//   polarity-corrected word, presented as groups of four bits (nibbles).
//   Each switch is synchronised into clk, optionally inverted, and debounced
//   by its own saturating counter. Every update of the debounced word comes
//   with a one-cycle strobe, a per-bit toggle mask and a per-nibble summary.
//
// Parameters:
//   WIDTH           switch count, a multiple of 4 and at least 4
//   ACTIVE_LOW      1: a closed switch reads 0, so the input is inverted
//                   0: the input is passed through unchanged
//   DEBOUNCE_CYCLES consecutive synchronised cycles of disagreement needed
//                   before a bit takes its new level (at least 1)
//
// Ports:
//   clk            single clock; all state updates on its rising edge
//   rstN           asynchronous, active-low reset
//   dipSwitch      raw, asynchronous, bouncing switch levels
//   freeze         synchronous hold: counters, state and strobes are held
//                  while high; the synchronisers keep running
//   nibbles        debounced, polarity-corrected value (nibble k is
//                  nibbles[4k+3:4k])
//   changed        one-cycle strobe in the cycle nibbles takes a new value
//   changeMask     bits that toggled in that update; zero otherwise
//   nibbleChanged  bit k is the OR of changeMask over nibble k
// ----------------------------------------------------------------------------
module switch_nibble_conditioner #(
  parameter int WIDTH           = 8,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic [WIDTH-1:0]     dipSwitch,
  input  logic                 freeze,
  output logic [WIDTH-1:0]     nibbles,
  output logic                 changed,
  output logic [WIDTH-1:0]     changeMask,
  output logic [WIDTH/4-1:0]   nibbleChanged
);

  localparam int NIBBLE_COUNT = WIDTH / 4;
  localparam int CW           = $clog2(DEBOUNCE_CYCLES) + 1;

  // Count value at which one more cycle of disagreement commits the new
  // level. The counter saturates here, so it can never wrap.
  localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

  // Synchronisers reset to the raw level of an open switch, so a switch
  // already closed while in reset is seen as a fresh change afterwards.
  localparam logic [WIDTH-1:0] SYNC_IDLE =
    (ACTIVE_LOW != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  logic [WIDTH-1:0]        sync1_reg;
  logic [WIDTH-1:0]        sync2_reg;
  logic [WIDTH-1:0]        sync_bit;
  logic [WIDTH-1:0]        state_reg;
  logic [WIDTH-1:0]        state_next;
  logic [WIDTH-1:0]        change_mask_next;
  logic [WIDTH-1:0]        change_mask_reg;
  logic                    changed_reg;
  logic [NIBBLE_COUNT-1:0] nibble_changed_next;
  logic [NIBBLE_COUNT-1:0] nibble_changed_reg;

  // --------------------------------------------------------------------------
  // Two-flop synchroniser; runs regardless of freeze.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sync1_reg <= SYNC_IDLE;
      sync2_reg <= SYNC_IDLE;
    end else begin
      sync1_reg <= dipSwitch;
      sync2_reg <= sync1_reg;
    end
  end

  assign sync_bit = (ACTIVE_LOW != 0) ? ~sync2_reg : sync2_reg;

  // --------------------------------------------------------------------------
  // Per-bit debounce counters. Each bit computes its own next state; the
  // debounced word itself is registered below so the toggle mask can be
  // formed from the same old/new pair.
  // --------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [CW-1:0] count_reg;
      logic [CW-1:0] count_next;
      logic          bit_next;

      always_comb begin
        count_next = count_reg;
        bit_next   = state_reg[gi];
        if (!freeze) begin
          if (sync_bit[gi] == state_reg[gi]) begin
            // Any agreement throws away a partial count.
            count_next = '0;
          end else if (count_reg == LAST_COUNT) begin
            bit_next   = sync_bit[gi];
            count_next = '0;
          end else begin
            count_next = count_reg + CW'(1);
          end
        end
      end

      always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
          count_reg <= '0;
        end else begin
          count_reg <= count_next;
        end
      end

      assign state_next[gi] = bit_next;
    end
  endgenerate

  assign change_mask_next = state_reg ^ state_next;

  generate
    for (gi = 0; gi < NIBBLE_COUNT; gi++) begin : g_nibble
      assign nibble_changed_next[gi] = |change_mask_next[4*gi +: 4];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Debounced word and change indications share one register stage, so the
  // strobe, mask and nibble summary line up with the first cycle of the new
  // value. While frozen state_next equals state_reg, so all of them read 0.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_reg          <= '0;
      change_mask_reg    <= '0;
      changed_reg        <= 1'b0;
      nibble_changed_reg <= '0;
    end else begin
      state_reg          <= state_next;
      change_mask_reg    <= change_mask_next;
      changed_reg        <= |change_mask_next;
      nibble_changed_reg <= nibble_changed_next;
    end
  end

  assign nibbles       = state_reg;
  assign changed       = changed_reg;
  assign changeMask    = change_mask_reg;
  assign nibbleChanged = nibble_changed_reg;

endmodule
